tpum_xbox_port: RTL
===================

TPUM_XBOX_PORT -- requirements
Module: tpum_xbox_port

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-002 Parameters SHALL be:
- ADDR_W, default 14, XBOX address width.
- DATA_W, default 1024, XBOX row width.
- RD_LAT, default 2, XBOX read latency in cycles, legal range 1..15.
REQ-003 Ports SHALL be, with widths:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle if valid.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  row address.
- req_wdata  in  DATA_W  write row.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes data.
- rsp_rdata  out  DATA_W  read row.
- xbox_rd  out  1  XBOX read strobe.
- xbox_wr  out  1  XBOX write strobe.
- xbox_addr  out  ADDR_W  XBOX address.
- xbox_wdata  out  DATA_W  XBOX write row.
- xbox_rdata  in  DATA_W  XBOX read row.
- busy  out  1  state != IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, one-hot encoded.
REQ-005 req_ready SHALL be 1 exactly when state==IDLE; a request is accepted on a clock edge where req_valid && req_ready.
REQ-006 On acceptance the block SHALL register req_wr, req_addr and req_wdata, and go to ISSUE.
REQ-007 In ISSUE, xbox_rd SHALL equal !wr_q and xbox_wr SHALL equal wr_q, both driven from registers; exactly one strobe is high, for exactly one cycle.
REQ-008 xbox_addr and xbox_wdata SHALL hold the registered values from ISSUE until the next acceptance, and SHALL be 0 after reset.
REQ-009 ISSUE SHALL transition as follows:
- write: to IDLE; no response is generated.
- read: to WAIT, with the latency counter loaded to RD_LAT-1.
REQ-010 In WAIT the counter SHALL decrement each cycle. When it is 0, xbox_rdata SHALL be captured into rsp_rdata on that edge and the state SHALL go to RESP. The capture edge is RD_LAT cycles after the xbox_rd cycle.
REQ-011 Latency SHALL be as follows, counting from the accept edge (cycle 0):
- read: xbox_rd high in cycle 1; rsp_valid high from cycle RD_LAT+2.
- write: xbox_wr high in cycle 1; req_ready high again in cycle 2.
REQ-012 rsp_valid SHALL be 1 exactly in RESP.
REQ-013 rsp_rdata SHALL be stable while rsp_valid && !rsp_ready.
REQ-014 RESP SHALL go to IDLE on the edge where rsp_ready==1. If rsp_ready is already high on entry to RESP, rsp_valid SHALL last exactly one cycle.
REQ-015 rsp_ready asserted outside RESP SHALL have no effect.
REQ-016 req_valid, req_wr and req_addr changes outside IDLE SHALL be ignored; no request is lost or duplicated.
REQ-017 xbox_rdata SHALL be ignored in every cycle except the capture edge.
REQ-018 xbox_rd and xbox_wr SHALL never both be 1.

Reset
REQ-019 While rst_n==0, the block SHALL hold the following values:
- state=IDLE, counter=0.
- wr_q=0, xbox_rd=0, xbox_wr=0, xbox_addr=0, xbox_wdata=0.
- rsp_valid=0, rsp_rdata=0, busy=0.
- req_ready=1.
REQ-020 Reset asserted mid-operation SHALL abort any pending read with no response. Late XBOX data SHALL be discarded, and the first cycle after deassertion is IDLE.

Structure
REQ-021 The state enum, TPUM_ADDR_W=14 and TPUM_DATA_W=1024 SHALL live in the shared package tpum_pkg, which is also used by the controller FSM.
REQ-022 No sub-module SHALL be used; the latency counter is inline.

Verification (RD_LAT=2)
REQ-023 Read addr 0x0005, XBOX returns 0xA5-pattern row in cycle 3 -> xbox_rd=1 only in cycle 1 with xbox_addr=0x0005; rsp_valid=1 in cycle 4 with rsp_rdata=A5-pattern.
REQ-024 Write addr 0x3FFF, data all-ones -> xbox_wr=1 only in cycle 1 with addr 0x3FFF and wdata all-ones; rsp_valid stays 0; req_ready=1 in cycle 2.
REQ-025 Read with rsp_ready held 0 for 5 cycles, while xbox_rdata toggles -> rsp_valid stays 1 and rsp_rdata is unchanged; on rsp_ready=1 the next cycle is IDLE.
REQ-026 req_valid held high across back-to-back write, read, write -> three single-cycle strobes in order; no strobe overlap; exactly one response.
REQ-027 rst_n pulsed low during WAIT -> all outputs go to reset values asynchronously; no rsp_valid after release; the next read completes normally.

Source files
------------

// File: rtl/tpum_pkg.sv
// Shared TPU-M definitions: XBOX geometry, latency counter width and the
// one-hot port/controller state encoding.
package tpum_pkg;

    localparam int TPUM_ADDR_W = 14;
    localparam int TPUM_DATA_W = 1024;
    // Wide enough for read latencies up to 15 cycles.
    localparam int TPUM_CNT_W  = 4;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        WAIT  = 4'b0100,
        RESP  = 4'b1000
    } tpum_state_e;

endpackage : tpum_pkg

// File: rtl/tpum_xbox_port.sv
// Single-outstanding request port in front of an XBOX row memory.
// A request is latched in IDLE, issued as a one-cycle strobe, and for reads
// the row is captured RD_LAT cycles after the strobe and held until taken.
module tpum_xbox_port
    import tpum_pkg::*;
#(
    parameter int ADDR_W = TPUM_ADDR_W,
    parameter int DATA_W = TPUM_DATA_W,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              xbox_rd,
    output logic              xbox_wr,
    output logic [ADDR_W-1:0] xbox_addr,
    output logic [DATA_W-1:0] xbox_wdata,
    input  logic [DATA_W-1:0] xbox_rdata,
    output logic              busy
);

    tpum_state_e           state;
    logic [TPUM_CNT_W-1:0] cnt;
    logic                  wr_q;

    // Handshake flags are pure decodes of the one-hot state register.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // Port controller: request latch, strobe generation, latency count, capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_q       <= 1'b0;
            xbox_rd    <= 1'b0;
            xbox_wr    <= 1'b0;
            xbox_addr  <= '0;
            xbox_wdata <= '0;
            rsp_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q       <= req_wr;
                        xbox_addr  <= req_addr;
                        xbox_wdata <= req_wdata;
                        // Strobes are set here so they are registered in ISSUE.
                        xbox_rd    <= !req_wr;
                        xbox_wr    <= req_wr;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    xbox_rd <= 1'b0;
                    xbox_wr <= 1'b0;
                    if (wr_q) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= TPUM_CNT_W'(RD_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_rdata <= xbox_rdata;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    xbox_rd <= 1'b0;
                    xbox_wr <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule : tpum_xbox_port
